sample_triplet_collector: RTL and testbench

Upstream feeder for the majority voter. Collects three consecutive temperature samples from the I2C sensor read path, holds them as a stable triplet (a/b/c), and hands the triplet over with a valid/ready handshake. Partial triplets are discarded when the sensor reports an error or when samples arrive too far apart, so the voter only ever sees three fresh, consecutive readings.

---
 rtl/sample_triplet_collector.sv | 144 ++++++++++++++
 tb/tb_sample_triplet_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_triplet_collector.sv
`default_nettype none
// sample_triplet_collector: gathers three consecutive sensor samples into a stable
// a/b/c triplet for the majority voter and hands it over with valid/ready. Rev 1.0
module sample_triplet_collector #(
    parameter int BIT_WIDTH   = 4,
    parameter int GAP_TIMEOUT = 1000,
    parameter int GAP_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] sample_in,
    input  logic                 sample_valid,
    input  logic                 sample_err,
    output logic [BIT_WIDTH-1:0] a_out,
    output logic [BIT_WIDTH-1:0] b_out,
    output logic [BIT_WIDTH-1:0] c_out,
    output logic                 set_valid,
    input  logic                 set_ready,
    output logic [1:0]           fill_level,
    output logic                 timeout_pulse,
    output logic                 err_pulse,
    output logic [7:0]           dropped_count
);

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_TIMEOUT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic [BIT_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic                 valid_q, valid_d;
    logic [1:0]           fill_q, fill_d;
    logic                 tp_q, tp_d;
    logic                 ep_q, ep_d;
    logic [7:0]           drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        tp_d    = 1'b0;
        ep_d    = 1'b0;
        drop_d  = drop_q;

        case (state_q)
            ST_FILL: begin
                if (sample_valid && sample_err) begin
                    idx_d = 2'd0;
                    gap_d = '0;
                    ep_d  = 1'b1;
                end else if (sample_valid) begin
                    case (idx_q)
                        2'd0:    a_d = sample_in;
                        2'd1:    b_d = sample_in;
                        default: c_d = sample_in;
                    endcase
                    gap_d = '0;
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = ST_PRESENT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (idx_q != 2'd0) begin
                    // A sample in the expiring cycle takes the branch above, so it always wins.
                    if (gap_q == GAP_LAST) begin
                        idx_d = 2'd0;
                        gap_d = '0;
                        tp_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
            end
            ST_PRESENT: begin
                if (set_ready) begin
                    state_d = ST_FILL;
                    idx_d   = 2'd0;
                    gap_d   = '0;
                    if (sample_valid && sample_err) begin
                        ep_d = 1'b1;
                    end else if (sample_valid) begin
                        a_d   = sample_in;
                        idx_d = 2'd1;
                    end
                end else if (sample_valid && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase

        valid_d = (state_d == ST_PRESENT);
        fill_d  = valid_d ? 2'd3 : idx_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            idx_q   <= 2'd0;
            gap_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            fill_q  <= 2'd0;
            tp_q    <= 1'b0;
            ep_q    <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
            tp_q    <= tp_d;
            ep_q    <= ep_d;
            drop_q  <= drop_d;
        end
    end

    assign a_out         = a_q;
    assign b_out         = b_q;
    assign c_out         = c_q;
    assign set_valid     = valid_q;
    assign fill_level    = fill_q;
    assign timeout_pulse = tp_q;
    assign err_pulse     = ep_q;
    assign dropped_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_triplet_collector.sv
`default_nettype none
// Bench for sample_triplet_collector: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_sample_triplet_collector;

    localparam int BW = 4;
    localparam int GT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_err;
    logic          set_ready;
    logic [BW-1:0] a_out, b_out, c_out;
    logic          set_valid;
    logic [1:0]    fill_level;
    logic          timeout_pulse;
    logic          err_pulse;
    logic [7:0]    dropped_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    sample_triplet_collector #(
        .BIT_WIDTH  (BW),
        .GAP_TIMEOUT(GT),
        .GAP_CNT_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_err   (sample_err),
        .a_out        (a_out),
        .b_out        (b_out),
        .c_out        (c_out),
        .set_valid    (set_valid),
        .set_ready    (set_ready),
        .fill_level   (fill_level),
        .timeout_pulse(timeout_pulse),
        .err_pulse    (err_pulse),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: partial triplet as a queue, idle cycles counted since the last sample.
    logic [BW-1:0] part[$];
    bit            m_held = 1'b0;
    logic [BW-1:0] m_a = '0, m_b = '0, m_c = '0;
    int            m_idle = 0;
    int            m_drop = 0;
    bit            m_tp = 1'b0, m_ep = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            part.delete();
            m_held = 1'b0;
            m_a = '0; m_b = '0; m_c = '0;
            m_idle = 0; m_drop = 0; m_tp = 1'b0; m_ep = 1'b0;
        end else begin
            m_tp = 1'b0;
            m_ep = 1'b0;
            if (m_held) begin
                if (set_ready) begin
                    m_held = 1'b0;
                    part.delete();
                    m_idle = 0;
                    if (sample_valid && sample_err) m_ep = 1'b1;
                    else if (sample_valid) part.push_back(sample_in);
                end else if (sample_valid && m_drop < 255) begin
                    m_drop++;
                end
            end else if (sample_valid && sample_err) begin
                part.delete();
                m_idle = 0;
                m_ep = 1'b1;
            end else if (sample_valid) begin
                part.push_back(sample_in);
                m_idle = 0;
                if (part.size() == 3) begin
                    m_a = part[0]; m_b = part[1]; m_c = part[2];
                    m_held = 1'b1;
                    part.delete();
                end
            end else if (part.size() > 0) begin
                m_idle++;
                if (m_idle == GT) begin
                    part.delete();
                    m_idle = 0;
                    m_tp = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_set_valid", 32'(set_valid), 32'(m_held));
            chk("m_fill_level", 32'(fill_level), m_held ? 32'd3 : 32'(part.size()));
            chk("m_timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
            chk("m_err_pulse", 32'(err_pulse), 32'(m_ep));
            chk("m_dropped_count", 32'(dropped_count), 32'(m_drop));
            if (m_held) begin
                chk("m_a_out", 32'(a_out), 32'(m_a));
                chk("m_b_out", 32'(b_out), 32'(m_b));
                chk("m_c_out", 32'(c_out), 32'(m_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [BW-1:0] v, input bit err);
        sample_in    = v;
        sample_valid = 1'b1;
        sample_err   = err;
        tick();
        sample_valid = 1'b0;
        sample_err   = 1'b0;
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, "_a"}, 32'(a_out), 0);
        chk({tag, "_b"}, 32'(b_out), 0);
        chk({tag, "_c"}, 32'(c_out), 0);
        chk({tag, "_set_valid"}, 32'(set_valid), 0);
        chk({tag, "_fill"}, 32'(fill_level), 0);
        chk({tag, "_tp"}, 32'(timeout_pulse), 0);
        chk({tag, "_ep"}, 32'(err_pulse), 0);
        chk({tag, "_drop"}, 32'(dropped_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; sample_err = 1'b0; set_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        expect_zero("reset");

        // First triplet, held with set_ready low
        idle(1); send(4'h3, 0); idle(1); send(4'h5, 0); idle(1);
        chk("pre_third_valid", 32'(set_valid), 0);
        send(4'h7, 0);
        chk("t1_valid", 32'(set_valid), 1);
        chk("t1_a", 32'(a_out), 32'h3);
        chk("t1_b", 32'(b_out), 32'h5);
        chk("t1_c", 32'(c_out), 32'h7);
        chk("t1_fill", 32'(fill_level), 3);
        idle(10);
        chk("hold_a", 32'(a_out), 32'h3);
        chk("hold_c", 32'(c_out), 32'h7);
        chk("hold_valid", 32'(set_valid), 1);

        // Transfer with a new sample in the same cycle
        set_ready = 1'b1; sample_in = 4'h9; sample_valid = 1'b1;
        tick();
        set_ready = 1'b0; sample_valid = 1'b0;
        chk("xfer_valid", 32'(set_valid), 0);
        chk("xfer_fill", 32'(fill_level), 1);
        chk("xfer_drop", 32'(dropped_count), 0);
        send(4'hB, 0); send(4'hD, 0);
        chk("t2_a", 32'(a_out), 32'h9);
        chk("t2_b", 32'(b_out), 32'hB);
        chk("t2_c", 32'(c_out), 32'hD);
        set_ready = 1'b1; tick(); set_ready = 1'b0;
        chk("xfer2_fill", 32'(fill_level), 0);

        // Gap timeout, then a sample on exactly the last idle cycle
        send(4'h1, 0); idle(GT - 1);
        chk("gap_before_tp", 32'(timeout_pulse), 0);
        chk("gap_before_fill", 32'(fill_level), 1);
        idle(1);
        chk("gap_tp", 32'(timeout_pulse), 1);
        chk("gap_fill", 32'(fill_level), 0);
        idle(1);
        chk("gap_tp_clear", 32'(timeout_pulse), 0);
        send(4'h2, 0); idle(GT - 1); send(4'h4, 0);
        chk("edge_tp", 32'(timeout_pulse), 0);
        chk("edge_fill", 32'(fill_level), 2);
        idle(GT);
        chk("edge_late_tp", 32'(timeout_pulse), 1);
        chk("edge_late_fill", 32'(fill_level), 0);

        // Error discards the partial triplet
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 1);
        chk("err_pulse", 32'(err_pulse), 1);
        chk("err_fill", 32'(fill_level), 0);
        idle(1);
        chk("err_pulse_clear", 32'(err_pulse), 0);
        send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
        chk("t3_a", 32'(a_out), 32'h6);
        chk("t3_b", 32'(b_out), 32'h7);
        chk("t3_c", 32'(c_out), 32'h8);

        // Drop saturation while held
        for (int i = 0; i < 300; i++) begin
            sample_in = BW'(i); sample_valid = 1'b1; sample_err = (i % 7 == 0);
            tick();
        end
        sample_valid = 1'b0; sample_err = 1'b0;
        chk("sat_drop", 32'(dropped_count), 255);
        chk("sat_a", 32'(a_out), 32'h6);
        chk("sat_valid", 32'(set_valid), 1);

        // Transfer cycle carrying an errored sample
        set_ready = 1'b1; sample_valid = 1'b1; sample_err = 1'b1;
        tick();
        set_ready = 1'b0; sample_valid = 1'b0; sample_err = 1'b0;
        chk("xerr_valid", 32'(set_valid), 0);
        chk("xerr_ep", 32'(err_pulse), 1);
        chk("xerr_fill", 32'(fill_level), 0);
        chk("xerr_drop", 32'(dropped_count), 255);

        // Reset mid-triplet and mid-handshake
        send(4'h1, 0); send(4'h2, 0);
        chk("pre_rst_fill", 32'(fill_level), 2);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_zero("rst_fill2");
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0);
        chk("pre_rst_valid", 32'(set_valid), 1);
        rst = 1'b1; set_ready = 1'b1; sample_valid = 1'b1; sample_in = 4'hF;
        tick();
        rst = 1'b0; set_ready = 1'b0; sample_valid = 1'b0;
        expect_zero("rst_present");
        send(4'h5, 0); send(4'h6, 0); send(4'h7, 0);
        chk("post_rst_a", 32'(a_out), 32'h5);
        chk("post_rst_c", 32'(c_out), 32'h7);
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
